// File: rtl/crossover_unit_pkg.sv
// -----------------------------------------------------------------------------
// crossover_unit_pkg
// Shared GA definitions for the crossover datapath: default gene width and
// genome length, crossover mode encodings, the crossover FSM state type and
// the per-gene pick rule.
// -----------------------------------------------------------------------------
package crossover_unit_pkg;

  localparam int GENE_W     = 4;
  localparam int GENOME_LEN = 16;

  typedef enum logic {
    XO_UNIFORM = 1'b0,
    XO_SINGLE  = 1'b1
  } xo_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } xo_state_e;

  // pick=1 means child0 takes parent B. Uniform mode follows the selector
  // stream; single-point mode swaps every gene at or beyond the cut index.
  function automatic logic xo_pick(input xo_mode_e mode,
                                   input logic     sel,
                                   input logic     past_cut);
    return (mode == XO_SINGLE) ? past_cut : sel;
  endfunction

endpackage

// File: rtl/crossover_unit_xo_out_stage.sv
// -----------------------------------------------------------------------------
// crossover_unit_xo_out_stage
// Single-entry valid/ready output register for the crossover unit. Holds one
// child pair together with its gene index and last flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                capture d_* this edge (caller guarantees the slot is
//                       empty or being drained in the same edge)
//   d_child0/d_child1   child genes to capture
//   d_idx, d_last       gene index and last-gene flag to capture
//   out_ready           downstream accepts the held pair
//   out_valid           held pair is valid
//   child0/child1       held child genes
//   out_idx, out_last   held index / last flag
// -----------------------------------------------------------------------------
module crossover_unit_xo_out_stage #(
  parameter int GENE_W = 4,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [GENE_W-1:0] d_child0,
  input  logic [GENE_W-1:0] d_child1,
  input  logic [IDX_W-1:0]  d_idx,
  input  logic              d_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [GENE_W-1:0] child0,
  output logic [GENE_W-1:0] child1,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  logic              valid_reg;
  logic [GENE_W-1:0] child0_reg;
  logic [GENE_W-1:0] child1_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      child0_reg <= '0;
      child1_reg <= '0;
      idx_reg    <= '0;
      last_reg   <= 1'b0;
    end else if (load) begin
      // A load while the current pair is being accepted reloads without a bubble.
      valid_reg  <= 1'b1;
      child0_reg <= d_child0;
      child1_reg <= d_child1;
      idx_reg    <= d_idx;
      last_reg   <= d_last;
    end else if (valid_reg && out_ready) begin
      // Data is left in place; only the valid flag drops.
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign child0    = child0_reg;
  assign child1    = child1_reg;
  assign out_idx   = idx_reg;
  assign out_last  = last_reg;

endmodule

// File: rtl/crossover_unit.sv
// -----------------------------------------------------------------------------
// crossover_unit
// Streaming gene-combining engine. For each genome it accepts GENOME_LEN
// parent gene pairs over valid/ready, applies uniform (select-driven) or
// single-point (cut-index-driven) crossover, and emits two complementary
// child genes per cycle through a registered output stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, mode, xpoint begin a genome (IDLE only); mode 0=uniform,
//                       1=single-point; xpoint is the cut index
//   in_valid/in_ready   parent pair handshake
//   gene_a, gene_b      parent genes
//   select              uniform-mode selector, 1 = child0 takes B
//   out_valid/out_ready child pair handshake
//   child0, child1      primary / complementary child genes
//   out_idx, out_last   gene index of the output, last-gene flag
//   busy                FSM not idle
//   done                one-cycle pulse after the last child pair is accepted
// -----------------------------------------------------------------------------
module crossover_unit
  import crossover_unit_pkg::*;
#(
  parameter int GENE_W     = crossover_unit_pkg::GENE_W,
  parameter int GENOME_LEN = crossover_unit_pkg::GENOME_LEN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                mode,
  input  logic [$clog2(GENOME_LEN):0]         xpoint,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [GENE_W-1:0]                   gene_a,
  input  logic [GENE_W-1:0]                   gene_b,
  input  logic                                select,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [GENE_W-1:0]                   child0,
  output logic [GENE_W-1:0]                   child1,
  output logic [$clog2(GENOME_LEN):0]         out_idx,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
);

  localparam int IDX_W = $clog2(GENOME_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GENOME_LEN - 1);

  xo_state_e         state_reg;
  xo_mode_e          mode_reg;
  logic [IDX_W-1:0]  xpoint_reg;
  logic [IDX_W-1:0]  cnt_reg;
  logic              done_reg;

  logic              out_valid_int;
  logic              in_ready_int;
  logic              accept;
  logic              is_last;
  logic              pick;
  logic [GENE_W-1:0] child0_next;
  logic [GENE_W-1:0] child1_next;

  // Only RUN takes input, and only when the output slot is free or draining.
  assign in_ready_int = (state_reg == ST_RUN) && (!out_valid_int || out_ready);
  assign accept       = in_valid && in_ready_int;
  assign is_last      = (cnt_reg == LAST_IDX);

  // Unsigned compare against a cut index that may exceed the genome length:
  // xpoint=0 swaps every gene, xpoint>=GENOME_LEN swaps none.
  assign pick        = xo_pick(mode_reg, select, (cnt_reg >= xpoint_reg));
  assign child0_next = pick ? gene_b : gene_a;
  assign child1_next = pick ? gene_a : gene_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= XO_UNIFORM;
      xpoint_reg <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_reg   <= xo_mode_e'(mode);
            xpoint_reg <= xpoint;
            cnt_reg    <= '0;
            state_reg  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_last) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The last pair was loaded on entry; wait for it to leave.
          if (out_valid_int && out_ready) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  crossover_unit_xo_out_stage #(
    .GENE_W (GENE_W),
    .IDX_W  (IDX_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .d_child0  (child0_next),
    .d_child1  (child1_next),
    .d_idx     (cnt_reg),
    .d_last    (is_last),
    .out_ready (out_ready),
    .out_valid (out_valid_int),
    .child0    (child0),
    .child1    (child1),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_int;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_crossover_unit.sv
// -----------------------------------------------------------------------------
// tb_crossover_unit
// Scoreboard bench for crossover_unit: the driver pushes the expected child
// pair for every accepted parent pair; an independent monitor pops and
// compares on every output handshake, checks stall stability and done timing.
// -----------------------------------------------------------------------------
module tb_crossover_unit;

  localparam int N  = 16;
  localparam int GW = 4;
  localparam int IW = 5;

  typedef struct packed {
    logic [GW-1:0] c0;
    logic [GW-1:0] c1;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [IW-1:0] xpoint;
  logic          in_valid;
  logic          in_ready;
  logic [GW-1:0] gene_a;
  logic [GW-1:0] gene_b;
  logic          select;
  logic          out_valid;
  logic          out_ready;
  logic [GW-1:0] child0;
  logic [GW-1:0] child1;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          done;

  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_hs_cyc = -10;
  int done_cyc    = 0;
  int done_count  = 0;
  int run_entry   = 0;

  logic          cur_mode;
  logic [IW-1:0] cur_xp;
  logic          held_valid = 1'b0;
  logic [13:0]   held;
  bit            aborted;

  crossover_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .xpoint    (xpoint),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gene_a    (gene_a),
    .gene_b    (gene_b),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .child0    (child0),
    .child1    (child1),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, when the driver has
  // settled this cycle's inputs, so a seen handshake completes on the next edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (held_valid)
        check("stall_hold", {child0, child1, out_idx, out_last}, held);
      held_valid = out_valid && !out_ready;
      held       = {child0, child1, out_idx, out_last};
      if (out_valid && out_ready) begin
        $display("out idx=%0d child0=%0h child1=%0h last=%0b", out_idx, child0, child1, out_last);
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got idx %0d, required no output (empty scoreboard)", out_idx);
        end else begin
          mon_e = sbq.pop_front();
          check("child0", child0, mon_e.c0);
          check("child1", child1, mon_e.c1);
          check("out_idx", out_idx, mon_e.idx);
          check("out_last", out_last, mon_e.last);
          if (mon_e.last) last_hs_cyc = cyc;
        end
      end
      if (done) begin
        check("done_timing", cyc, last_hs_cyc + 1);
        done_count++;
        done_cyc = cyc;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_child0"},    child0,    0);
    check({tag, "_child1"},    child1,    0);
    check({tag, "_out_idx"},   out_idx,   0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  task automatic do_start(input logic m, input logic [IW-1:0] xp);
    @(negedge clk);
    start    = 1'b1;
    mode     = m;
    xpoint   = xp;
    in_valid = 1'b0;
    cur_mode = m;
    cur_xp   = xp;
    $display("start mode=%0d xpoint=%0d", m, xp);
  endtask

  // sel_pat 0 = alternating select, 1 = random select.
  task automatic feed(input int sel_pat, input bit bp, input int mid_idx,
                      input int rst_idx, output bit was_aborted);
    int   idx   = 0;
    int   guard = 0;
    bit   first = 1'b1;
    logic pk;
    exp_t e;
    was_aborted = 1'b0;
    while (idx < N && guard < 400) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (first) begin
        check("busy_after_start", busy, 1);
        run_entry = cyc;
        first = 1'b0;
      end
      if (idx == rst_idx) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        $display("reset pulse at idx=%0d", idx);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        was_aborted = 1'b1;
        return;
      end
      in_valid  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      gene_a    = GW'(idx);
      gene_b    = GW'(15 - idx);
      select    = (sel_pat == 0) ? idx[0] : 1'($urandom_range(0, 1));
      if (idx == mid_idx) begin
        start  = 1'b1;
        mode   = ~cur_mode;
        xpoint = '0;
      end
      #1;
      if (in_valid && in_ready) begin
        pk     = cur_mode ? (idx >= int'(cur_xp)) : select;
        e.c0   = pk ? gene_b : gene_a;
        e.c1   = pk ? gene_a : gene_b;
        e.idx  = IW'(idx);
        e.last = (idx == N - 1);
        sbq.push_back(e);
        idx++;
      end
    end
    if (guard >= 400) check("feed_timeout", idx, N);
  endtask

  task automatic finish_genome(input bit bp);
    int n0 = done_count;
    int g  = 0;
    while (done_count == n0 && g < 200) begin
      @(negedge clk);
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      g++;
    end
    check("done_seen", done_count, n0 + 1);
    if (!bp) check("genome_cycles", done_cyc - run_entry, N + 1);
    check("sb_empty", sbq.size(), 0);
    check("idle_after_done", busy, 0);
    $display("genome complete, done at cycle %0d", done_cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; xpoint = '0;
    in_valid = 1'b0; gene_a = '0; gene_b = '0; select = 1'b0; out_ready = 1'b0;
    cur_mode = 1'b0; cur_xp = '0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // in_valid in IDLE must not be accepted
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("idle_no_output", out_valid, 0);

    // Uniform, alternating select: child0 = 0,14,2,12,...
    do_start(1'b0, 5'd0);
    feed(0, 1'b0, -1, -1, aborted);
    finish_genome(1'b0);

    // Single-point cut at 5, select randomised but irrelevant
    do_start(1'b1, 5'd5);
    feed(1, 1'b0, -1, -1, aborted);
    finish_genome(1'b0);

    // Cut at 0: every child0 from B
    do_start(1'b1, 5'd0);
    feed(1, 1'b0, -1, -1, aborted);
    finish_genome(1'b0);

    // Cut at 16: every child0 from A
    do_start(1'b1, 5'd16);
    feed(1, 1'b0, -1, -1, aborted);
    finish_genome(1'b0);

    // Random backpressure on both sides, uniform random select
    do_start(1'b0, 5'd3);
    feed(1, 1'b1, -1, -1, aborted);
    finish_genome(1'b1);

    // start with a different mode/xpoint at idx 7 must be ignored
    do_start(1'b1, 5'd5);
    feed(1, 1'b0, 7, -1, aborted);
    finish_genome(1'b0);

    // Reset at idx 9, then a clean genome under backpressure
    do_start(1'b0, 5'd0);
    feed(0, 1'b0, -1, 9, aborted);
    check("rst_aborted", aborted, 1);
    do_start(1'b1, 5'd9);
    feed(1, 1'b1, -1, -1, aborted);
    finish_genome(1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
